// File: rtl/lockstep_commit_checker.sv
// rtl/lockstep_commit_checker.sv - golden vs segmented core writeback lockstep checker
//
// Queues golden-core register writebacks and compares each segmented-core
// writeback against the oldest queued golden entry. The first discrepancy
// latches diagnostics and freezes the block until clear or reset.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   clear                         synchronous flush / error clear
//   gold_valid/gold_rd/gold_data  golden writeback event
//   seg_valid/seg_rd/seg_data     segmented writeback event
//   match_count                   successful comparisons (saturating)
//   pending                       golden FIFO occupancy
//   error, err_code               sticky failure flag and cause
//   err_gold_*, err_seg_*         expected / offending entries at failure
//   err_index                     match_count value at failure
module lockstep_commit_checker #(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 32,
    parameter bit FILTER_X0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     gold_valid,
    input  logic [ADDR_W-1:0]        gold_rd,
    input  logic [XLEN-1:0]          gold_data,
    input  logic                     seg_valid,
    input  logic [ADDR_W-1:0]        seg_rd,
    input  logic [XLEN-1:0]          seg_data,
    output logic [CNT_W-1:0]         match_count,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     error,
    output logic [2:0]               err_code,
    output logic [ADDR_W-1:0]        err_gold_rd,
    output logic [XLEN-1:0]          err_gold_data,
    output logic [ADDR_W-1:0]        err_seg_rd,
    output logic [XLEN-1:0]          err_seg_data,
    output logic [CNT_W-1:0]         err_index
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_DATA  = 3'd1;
    localparam logic [2:0] ERR_RD    = 3'd2;
    localparam logic [2:0] ERR_UNDER = 3'd3;
    localparam logic [2:0] ERR_OVER  = 3'd4;
    localparam logic [2:0] ERR_TMO   = 3'd5;

    typedef enum logic {ST_RUN, ST_FAIL} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem_rd_q   [DEPTH];
    logic [ADDR_W-1:0]   mem_rd_d   [DEPTH];
    logic [XLEN-1:0]     mem_data_q [DEPTH];
    logic [XLEN-1:0]     mem_data_d [DEPTH];
    // Pointers carry one extra wrap bit so full and empty differ.
    logic [OCC_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0]    match_count_q, match_count_d;
    logic [2:0]          err_code_q, err_code_d;
    logic [ADDR_W-1:0]   err_gold_rd_q, err_gold_rd_d;
    logic [XLEN-1:0]     err_gold_data_q, err_gold_data_d;
    logic [ADDR_W-1:0]   err_seg_rd_q, err_seg_rd_d;
    logic [XLEN-1:0]     err_seg_data_q, err_seg_data_d;
    logic [CNT_W-1:0]    err_index_q, err_index_d;

    logic                g_v, s_v;
    logic [OCC_W-1:0]    occ;
    logic                empty, full;
    logic [ADDR_W-1:0]   head_rd;
    logic [XLEN-1:0]     head_data;
    logic [2:0]          code;

    always_comb begin
        g_v       = gold_valid && !(FILTER_X0 && (gold_rd == '0));
        s_v       = seg_valid  && !(FILTER_X0 && (seg_rd  == '0));
        occ       = wr_ptr_q - rd_ptr_q;
        empty     = (occ == '0);
        full      = (occ == OCC_W'(DEPTH));
        head_rd   = mem_rd_q[rd_ptr_q[PTR_W-1:0]];
        head_data = mem_data_q[rd_ptr_q[PTR_W-1:0]];

        // Error detection in priority order: rd > data > underflow > overflow > timeout.
        code = ERR_NONE;
        if (s_v && !empty) begin
            if (seg_rd != head_rd) begin
                code = ERR_RD;
            end else if (seg_data != head_data) begin
                code = ERR_DATA;
            end
        end else if (s_v) begin
            code = ERR_UNDER;
        end
        // A matching pop at full frees the slot the push needs.
        if (code == ERR_NONE && g_v && full && !s_v) begin
            code = ERR_OVER;
        end
        // The counter increments once per idle non-empty cycle; the increment that
        // would reach TIMEOUT is the failing cycle.
        if (code == ERR_NONE && !s_v && !empty && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
            code = ERR_TMO;
        end
    end

    always_comb begin
        state_d         = state_q;
        mem_rd_d        = mem_rd_q;
        mem_data_d      = mem_data_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        tmo_d           = tmo_q;
        match_count_d   = match_count_q;
        err_code_d      = err_code_q;
        err_gold_rd_d   = err_gold_rd_q;
        err_gold_data_d = err_gold_data_q;
        err_seg_rd_d    = err_seg_rd_q;
        err_seg_data_d  = err_seg_data_q;
        err_index_d     = err_index_q;

        if (clear) begin
            state_d         = ST_RUN;
            wr_ptr_d        = '0;
            rd_ptr_d        = '0;
            tmo_d           = '0;
            match_count_d   = '0;
            err_code_d      = ERR_NONE;
            err_gold_rd_d   = '0;
            err_gold_data_d = '0;
            err_seg_rd_d    = '0;
            err_seg_data_d  = '0;
            err_index_d     = '0;
        end else if (state_q == ST_RUN) begin
            if (code != ERR_NONE) begin
                // The failing cycle leaves FIFO and counters untouched.
                state_d     = ST_FAIL;
                err_code_d  = code;
                err_index_d = match_count_q;
                case (code)
                    ERR_UNDER: begin
                        err_gold_rd_d   = '0;
                        err_gold_data_d = '0;
                        err_seg_rd_d    = seg_rd;
                        err_seg_data_d  = seg_data;
                    end
                    ERR_OVER: begin
                        err_gold_rd_d   = gold_rd;
                        err_gold_data_d = gold_data;
                        err_seg_rd_d    = '0;
                        err_seg_data_d  = '0;
                    end
                    ERR_TMO: begin
                        err_gold_rd_d   = head_rd;
                        err_gold_data_d = head_data;
                        err_seg_rd_d    = '0;
                        err_seg_data_d  = '0;
                    end
                    default: begin
                        err_gold_rd_d   = head_rd;
                        err_gold_data_d = head_data;
                        err_seg_rd_d    = seg_rd;
                        err_seg_data_d  = seg_data;
                    end
                endcase
            end else begin
                tmo_d = (s_v || empty) ? '0 : tmo_q + TMO_W'(1);
                if (s_v) begin
                    rd_ptr_d = rd_ptr_q + OCC_W'(1);
                    if (match_count_q != '1) begin
                        match_count_d = match_count_q + CNT_W'(1);
                    end
                end
                if (g_v) begin
                    mem_rd_d[wr_ptr_q[PTR_W-1:0]]   = gold_rd;
                    mem_data_d[wr_ptr_q[PTR_W-1:0]] = gold_data;
                    wr_ptr_d = wr_ptr_q + OCC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_RUN;
            for (int i = 0; i < DEPTH; i++) begin
                mem_rd_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            tmo_q           <= '0;
            match_count_q   <= '0;
            err_code_q      <= ERR_NONE;
            err_gold_rd_q   <= '0;
            err_gold_data_q <= '0;
            err_seg_rd_q    <= '0;
            err_seg_data_q  <= '0;
            err_index_q     <= '0;
        end else begin
            state_q         <= state_d;
            mem_rd_q        <= mem_rd_d;
            mem_data_q      <= mem_data_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            tmo_q           <= tmo_d;
            match_count_q   <= match_count_d;
            err_code_q      <= err_code_d;
            err_gold_rd_q   <= err_gold_rd_d;
            err_gold_data_q <= err_gold_data_d;
            err_seg_rd_q    <= err_seg_rd_d;
            err_seg_data_q  <= err_seg_data_d;
            err_index_q     <= err_index_d;
        end
    end

    assign match_count   = match_count_q;
    assign pending       = wr_ptr_q - rd_ptr_q;
    assign error         = (state_q == ST_FAIL);
    assign err_code      = err_code_q;
    assign err_gold_rd   = err_gold_rd_q;
    assign err_gold_data = err_gold_data_q;
    assign err_seg_rd    = err_seg_rd_q;
    assign err_seg_data  = err_seg_data_q;
    assign err_index     = err_index_q;

endmodule

// File: tb/tb_lockstep_commit_checker.sv
// tb/tb_lockstep_commit_checker.sv - self-checking bench for lockstep_commit_checker
module tb_lockstep_commit_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        gold_valid;
    logic [4:0]  gold_rd;
    logic [31:0] gold_data;
    logic        seg_valid;
    logic [4:0]  seg_rd;
    logic [31:0] seg_data;
    logic [31:0] match_count;
    logic [3:0]  pending;
    logic        error;
    logic [2:0]  err_code;
    logic [4:0]  err_gold_rd;
    logic [31:0] err_gold_data;
    logic [4:0]  err_seg_rd;
    logic [31:0] err_seg_data;
    logic [31:0] err_index;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lockstep_commit_checker dut (
        .clk(clk), .reset(reset), .clear(clear),
        .gold_valid(gold_valid), .gold_rd(gold_rd), .gold_data(gold_data),
        .seg_valid(seg_valid), .seg_rd(seg_rd), .seg_data(seg_data),
        .match_count(match_count), .pending(pending), .error(error), .err_code(err_code),
        .err_gold_rd(err_gold_rd), .err_gold_data(err_gold_data),
        .err_seg_rd(err_seg_rd), .err_seg_data(err_seg_data), .err_index(err_index)
    );

    // Reference model: a queue of outstanding golden writebacks plus scoreboard state.
    typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
    ent_t        q[$];
    int          m_idle;
    logic [31:0] m_cnt;
    bit          m_fail;
    int          m_code;
    logic [4:0]  m_grd, m_srd;
    logic [31:0] m_gdata, m_sdata, m_idx;

    task automatic model_reset();
        q.delete();
        m_idle = 0; m_cnt = 0; m_fail = 0; m_code = 0;
        m_grd = 0; m_srd = 0; m_gdata = 0; m_sdata = 0; m_idx = 0;
    endtask

    task automatic model_step(input bit gv, input logic [4:0] grd, input logic [31:0] gd,
                              input bit sv, input logic [4:0] srd, input logic [31:0] sd,
                              input bit clr);
        int code;
        if (clr) begin
            model_reset();
            return;
        end
        if (m_fail) return;
        gv = gv && (grd != 0);
        sv = sv && (srd != 0);
        code = 0;
        if (sv && q.size() == 0)          code = 3;
        else if (sv && srd != q[0].rd)    code = 2;
        else if (sv && sd != q[0].data)   code = 1;
        else if (gv && !sv && q.size() == 8) code = 4;
        else if (!sv && q.size() > 0 && m_idle + 1 >= 64) code = 5;
        if (code != 0) begin
            m_fail = 1; m_code = code; m_idx = m_cnt;
            m_grd = 0; m_gdata = 0; m_srd = 0; m_sdata = 0;
            if (code == 4) begin m_grd = grd; m_gdata = gd; end
            else if (code != 3) begin m_grd = q[0].rd; m_gdata = q[0].data; end
            if (code <= 3) begin m_srd = srd; m_sdata = sd; end
            return;
        end
        m_idle = (sv || q.size() == 0) ? 0 : m_idle + 1;
        if (sv) begin
            void'(q.pop_front());
            if (m_cnt != 32'hffff_ffff) m_cnt++;
        end
        if (gv) q.push_back('{rd: grd, data: gd});
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".match_count"}, 64'(match_count), 64'(m_cnt));
        check({tag, ".pending"}, 64'(pending), 64'(q.size()));
        check({tag, ".error"}, 64'(error), 64'(m_fail));
        check({tag, ".err_code"}, 64'(err_code), 64'(m_code));
        check({tag, ".err_gold_rd"}, 64'(err_gold_rd), 64'(m_grd));
        check({tag, ".err_gold_data"}, 64'(err_gold_data), 64'(m_gdata));
        check({tag, ".err_seg_rd"}, 64'(err_seg_rd), 64'(m_srd));
        check({tag, ".err_seg_data"}, 64'(err_seg_data), 64'(m_sdata));
        check({tag, ".err_index"}, 64'(err_index), 64'(m_idx));
    endtask

    task automatic step(input string tag,
                        input bit gv, input logic [4:0] grd, input logic [31:0] gd,
                        input bit sv, input logic [4:0] srd, input logic [31:0] sd,
                        input bit clr);
        gold_valid = gv; gold_rd = grd; gold_data = gd;
        seg_valid  = sv; seg_rd  = srd; seg_data  = sd;
        clear      = clr;
        @(posedge clk);
        model_step(gv, grd, gd, sv, srd, sd, clr);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_clear(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        ent_t e;
        reset = 1'b1; clear = 1'b0;
        gold_valid = 0; gold_rd = 0; gold_data = 0;
        seg_valid = 0; seg_rd = 0; seg_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Three golden writes, matched by the segmented side later.
        step("tp1_g1", 1, 1, 5, 0, 0, 0, 0);
        step("tp1_g2", 1, 2, 7, 0, 0, 0, 0);
        step("tp1_g3", 1, 3, 9, 0, 0, 0, 0);
        idle("tp1_i");
        step("tp1_s1", 0, 0, 0, 1, 1, 5, 0);
        step("tp1_s2", 0, 0, 0, 1, 2, 7, 0);
        step("tp1_s3", 0, 0, 0, 1, 3, 9, 0);
        check("tp1_count", 64'(match_count), 64'd3);
        check("tp1_pending", 64'(pending), 64'd0);
        check("tp1_error", 64'(error), 64'd0);

        // Data mismatch, frozen outputs, clear.
        do_clear("tp2_clr0");
        step("tp2_g", 1, 4, 32'h10, 0, 0, 0, 0);
        step("tp2_s", 0, 0, 0, 1, 4, 32'h11, 0);
        check("tp2_code", 64'(err_code), 64'd1);
        check("tp2_gdata", 64'(err_gold_data), 64'h10);
        check("tp2_sdata", 64'(err_seg_data), 64'h11);
        step("tp2_frz1", 1, 8, 32'h55, 1, 9, 32'h66, 0);
        step("tp2_frz2", 1, 8, 32'h55, 0, 0, 0, 0);
        check("tp2_frozen_code", 64'(err_code), 64'd1);
        do_clear("tp2_clr");
        check("tp2_clr_error", 64'(error), 64'd0);

        // Underflow, then rd mismatch.
        step("tp3_under", 0, 0, 0, 1, 5, 32'h1, 0);
        check("tp3_under_code", 64'(err_code), 64'd3);
        do_clear("tp3_clr1");
        step("tp3_g6", 1, 6, 32'hab, 0, 0, 0, 0);
        step("tp3_s7", 0, 0, 0, 1, 7, 32'hab, 0);
        check("tp3_rd_code", 64'(err_code), 64'd2);
        do_clear("tp3_clr2");

        // Full FIFO: overflow, then push+pop at full.
        for (int i = 0; i < 8; i++) step("tp4_fill", 1, 5'(i + 1), 32'(i * 3), 0, 0, 0, 0);
        check("tp4_full", 64'(pending), 64'd8);
        step("tp4_over", 1, 9, 32'h99, 0, 0, 0, 0);
        check("tp4_over_code", 64'(err_code), 64'd4);
        check("tp4_over_grd", 64'(err_gold_rd), 64'd9);
        do_clear("tp4_clr1");
        for (int i = 0; i < 8; i++) step("tp4_fill2", 1, 5'(i + 1), 32'(i * 3), 0, 0, 0, 0);
        step("tp4_pushpop", 1, 9, 32'h99, 1, 1, 0, 0);
        check("tp4_pp_error", 64'(error), 64'd0);
        check("tp4_pp_pending", 64'(pending), 64'd8);
        do_clear("tp4_clr2");

        // Timeout at cycle 64, avoided by a match at cycle 63.
        step("tp5_push", 1, 1, 32'h77, 0, 0, 0, 0);
        for (int i = 1; i < 64; i++) idle("tp5_wait");
        check("tp5_no_err_63", 64'(error), 64'd0);
        idle("tp5_64");
        check("tp5_tmo_code", 64'(err_code), 64'd5);
        do_clear("tp5_clr1");
        step("tp5b_push", 1, 1, 32'h77, 0, 0, 0, 0);
        for (int i = 1; i < 63; i++) idle("tp5b_wait");
        step("tp5b_match", 0, 0, 0, 1, 1, 32'h77, 0);
        for (int i = 0; i < 4; i++) idle("tp5b_after");
        check("tp5b_error", 64'(error), 64'd0);
        do_clear("tp5_clr2");

        // x0 writes interleaved with real writes.
        step("tp6_a", 1, 0, 32'h1, 0, 0, 0, 0);
        step("tp6_b", 1, 3, 32'h3, 1, 0, 32'h2, 0);
        step("tp6_c", 1, 0, 32'h4, 1, 3, 32'h3, 0);
        step("tp6_d", 1, 4, 32'h5, 1, 0, 32'h9, 0);
        step("tp6_e", 0, 0, 0, 1, 4, 32'h5, 0);
        check("tp6_count", 64'(match_count), 64'd2);
        check("tp6_error", 64'(error), 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            bit gv, sv, clr;
            logic [4:0] grd, srd;
            logic [31:0] gd, sd;
            gv  = ($urandom_range(0, 2) != 0);
            grd = 5'($urandom_range(0, 7));
            gd  = $urandom;
            sv  = 0; srd = 0; sd = 0;
            if ($urandom_range(0, 2) != 0 && q.size() != 0) begin
                e = q[0];
                sv = 1; srd = e.rd; sd = e.data;
                if ($urandom_range(0, 60) == 0) sd = sd ^ 32'h4;
                if ($urandom_range(0, 60) == 0) srd = srd + 5'd1;
            end else if ($urandom_range(0, 30) == 0) begin
                sv = 1; srd = 5'($urandom_range(0, 3)); sd = $urandom;
            end
            clr = m_fail ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 150) == 0);
            step("rand", gv, grd, gd, sv, srd, sd, clr);
        end

        // Asynchronous reset in the middle of traffic.
        do_clear("tp7_clr");
        step("tp7_g", 1, 2, 32'h22, 0, 0, 0, 0);
        step("tp7_m", 1, 3, 32'h33, 1, 2, 32'h22, 0);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("tp7_async_reset");
        check("tp7_count_zero", 64'(match_count), 64'd0);
        check("tp7_pending_zero", 64'(pending), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        gold_valid = 0; seg_valid = 0;
        step("tp7_after", 1, 5, 32'h5, 0, 0, 0, 0);
        step("tp7_after_m", 0, 0, 0, 1, 5, 32'h5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lockstep_commit_checker.md
Name: lockstep_commit_checker

Overview:
- Runs the golden single-cycle core and the segmented pipelined core in lockstep and checks their register-file writeback streams against each other.
- Golden writebacks are queued in a FIFO. Each segmented writeback is checked against the queue head, which absorbs the pipeline latency difference.
- On the first discrepancy the block latches diagnostics and freezes. It sits beside the two core instances in the top level, is simulation-oriented and is synthesizable.

Parameters:
- XLEN, 32, writeback data width.
- ADDR_W, 5, register index width.
- DEPTH, 8, golden FIFO entries; power of two, >=2.
- TIMEOUT, 64, maximum cycles the FIFO may stay non-empty with no segmented writeback.
- CNT_W, 32, width of match counter.
- FILTER_X0, 1, when 1, writebacks with rd==0 are dropped on both inputs.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- clear  in  1  synchronous: flush FIFO, zero counters, clear error, return to RUN
- gold_valid  in  1  golden core writes the register file this cycle
- gold_rd  in  ADDR_W  golden destination register
- gold_data  in  XLEN  golden writeback value
- seg_valid  in  1  segmented core writes the register file this cycle
- seg_rd  in  ADDR_W  segmented destination register
- seg_data  in  XLEN  segmented writeback value
- match_count  out  CNT_W  number of successful comparisons
- pending  out  $clog2(DEPTH)+1  FIFO occupancy
- error  out  1  sticky failure flag
- err_code  out  3  0 none, 1 data mismatch, 2 rd mismatch, 3 underflow, 4 overflow, 5 timeout
- err_gold_rd / err_gold_data  out  ADDR_W / XLEN  expected entry at failure
- err_seg_rd / err_seg_data  out  ADDR_W / XLEN  offending segmented entry
- err_index  out  CNT_W  match_count value at failure

Behaviour:
- Reset (async) and clear (sync): state RUN; FIFO empty; every output 0.
- Filtering: with FILTER_X0=1, an event with rd==0 is treated as valid=0.
- FIFO push: a golden event is written at the tail. It is visible at the head the following cycle.
- Comparison: a segmented event compares against the FIFO head and pops it. Comparing against a golden event arriving in the same cycle is not allowed; there is no bypass.
- Empty FIFO: a segmented event with the FIFO empty gives underflow (code 3). err_gold_* = 0.
- Mismatch: seg_rd != head rd gives code 2, which takes precedence over data. Equal rd with unequal data gives code 1.
- Match: match_count += 1, saturating at all-ones.
- Full FIFO:
  - Push with a simultaneous pop is legal and occupancy is unchanged.
  - Push without a pop gives overflow (code 4). The push is discarded. err_gold_* = incoming event, err_seg_* = 0.
- Timeout counter: resets to 0 on any segmented event or when the FIFO is empty, otherwise increments. Reaching TIMEOUT gives code 5 with err_gold_* = head.
- Error priority within one cycle: 2 > 1 > 3 > 4 > 5. Only one code is captured.
- Error timing: error and all err_* registers update on the clock edge that samples the offending inputs. They are valid the cycle after the event.
- FSM:
  - RUN -> FAIL on any error condition.
  - FAIL holds until clear or reset; all inputs are ignored, FIFO and counters freeze, outputs hold.
  - FAIL -> RUN on clear only.
  - clear in RUN also flushes. clear has priority over inputs sampled the same cycle.
- Pointers: wrap modulo DEPTH. Occupancy is tracked with an extra bit so full and empty are distinguishable.
- Reset mid-operation: everything returns to its reset value immediately (asynchronous). No partial state survives.

Test Plan:
- 3 golden writes (x1=5, x2=7, x3=9), then the same 3 from the segmented side 4 cycles later -> match_count=3, pending=0, error=0.
- Golden x4=0x10, segmented x4=0x11 -> error=1, err_code=1, err_gold_data=0x10, err_seg_data=0x11, err_index=0; further inputs leave outputs frozen; clear -> all zero.
- Segmented x5 write with FIFO empty -> err_code=3. Separately, golden x6 vs segmented x7 -> err_code=2.
- DEPTH=8: 8 golden pushes with no pops -> pending=8. 9th push alone -> err_code=4. Repeat with a simultaneous push+pop at full -> no error, pending=8.
- One golden push, no segmented activity for 64 cycles -> err_code=5 on cycle 64; with a segmented match at cycle 63 -> no error.
- Golden and segmented writes to x0 interleaved with real writes -> ignored, match_count counts only non-x0 writes. Assert reset mid-stream -> outputs 0 same cycle.
